// File: rtl/demux4_dispatch_ctrl.sv
// demux4_dispatch_ctrl: valid/ready 1-to-4 dispatch controller with addressed/round-robin steering and stall timeout
module demux4_dispatch_ctrl #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_dest,
   input  logic              mode,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        sel,
   output logic              busy,
   output logic              drop_pulse,
   output logic [7:0]        drop_cnt
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state;
   logic [1:0] rr_ptr;
   logic [1:0] rr_nxt;
   logic [CW-1:0] wait_cnt;
   logic word_rr;
   logic xfer;
   logic drop;
   logic take;
   // per-cycle handshake decisions; rr_nxt already reflects a pointer advance so a
   // back-to-back round-robin word picks the following channel
   always_comb begin
      xfer = (state == SEND) && out_ready[sel];
      drop = (TIMEOUT > 0) && (state == SEND) && !out_ready[sel] && (wait_cnt == TLIM);
      in_ready = rst_n && ((state == IDLE) || xfer);
      take = in_valid && in_ready;
      rr_nxt = rr_ptr + 2'((xfer || drop) && word_rr);
      out_valid = (state == SEND) ? 4'b0001 << sel : 4'b0000;
      busy = state == SEND;
   end
   // FSM, held word, stall timer and drop accounting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         out_data <= '0;
         sel <= '0;
         rr_ptr <= '0;
         wait_cnt <= '0;
         word_rr <= 1'b0;
         drop_pulse <= 1'b0;
         drop_cnt <= '0;
      end else begin
         rr_ptr <= rr_nxt;
         drop_pulse <= drop;
         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
         if (take) begin
            state <= SEND;
            out_data <= in_data;
            sel <= mode ? rr_nxt : in_dest;
            word_rr <= mode;
            wait_cnt <= '0;
         end else if (xfer || drop)
            state <= IDLE;
         else if (state == SEND && wait_cnt != '1)
            wait_cnt <= wait_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_demux4_dispatch_ctrl.sv
// tb_demux4_dispatch_ctrl: directed table and sequence checks for demux4_dispatch_ctrl
module tb_demux4_dispatch_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic mode = 1'b0;
   logic in_ready;
   logic busy;
   logic drop_pulse;
   logic [7:0] in_data = 8'h00;
   logic [7:0] out_data;
   logic [7:0] drop_cnt;
   logic [1:0] in_dest = 2'd0;
   logic [1:0] sel;
   logic [3:0] out_valid;
   logic [3:0] out_ready = 4'h0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   demux4_dispatch_ctrl #(.DATA_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dest(in_dest), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .sel(sel), .busy(busy),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic v; logic [7:0] d; logic [1:0] dst; logic m; logic [3:0] rdy;
      logic e_ir; logic [3:0] e_ov; logic [7:0] e_d; logic [1:0] e_sel; logic e_busy;
   } vec_t;
   vec_t tbl [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dst, input logic m, input logic [3:0] rdy);
      in_valid = v;
      in_data = d;
      in_dest = dst;
      mode = m;
      out_ready = rdy;
      #1;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      tbl[0]  = '{1'b1, 8'hA0, 2'd3, 1'b0, 4'hF, 1'b1, 4'h0, 8'h00, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 8'hA1, 2'd0, 1'b0, 4'hF, 1'b1, 4'h8, 8'hA0, 2'd3, 1'b1};
      tbl[2]  = '{1'b1, 8'hA2, 2'd2, 1'b0, 4'hF, 1'b1, 4'h1, 8'hA1, 2'd0, 1'b1};
      tbl[3]  = '{1'b1, 8'hA3, 2'd1, 1'b0, 4'hF, 1'b1, 4'h4, 8'hA2, 2'd2, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b1, 4'h2, 8'hA3, 2'd1, 1'b1};
      tbl[5]  = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 8'hA3, 2'd1, 1'b0};
      tbl[6]  = '{1'b1, 8'hB0, 2'd3, 1'b1, 4'hF, 1'b1, 4'h0, 8'hA3, 2'd1, 1'b0};
      tbl[7]  = '{1'b1, 8'hB1, 2'd3, 1'b1, 4'hF, 1'b1, 4'h1, 8'hB0, 2'd0, 1'b1};
      tbl[8]  = '{1'b1, 8'hB2, 2'd3, 1'b1, 4'hF, 1'b1, 4'h2, 8'hB1, 2'd1, 1'b1};
      tbl[9]  = '{1'b1, 8'hB3, 2'd3, 1'b1, 4'hF, 1'b1, 4'h4, 8'hB2, 2'd2, 1'b1};
      tbl[10] = '{1'b1, 8'hB4, 2'd3, 1'b1, 4'hF, 1'b1, 4'h8, 8'hB3, 2'd3, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 2'd3, 1'b1, 4'hF, 1'b1, 4'h1, 8'hB4, 2'd0, 1'b1};
      tbl[12] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 8'hB4, 2'd0, 1'b0};
      tbl[13] = '{1'b1, 8'h5A, 2'd2, 1'b0, 4'hF, 1'b1, 4'h0, 8'hB4, 2'd0, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hB, 1'b0, 4'h4, 8'h5A, 2'd2, 1'b1};
      tbl[15] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hB, 1'b0, 4'h4, 8'h5A, 2'd2, 1'b1};
      tbl[16] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hB, 1'b0, 4'h4, 8'h5A, 2'd2, 1'b1};
      tbl[17] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'h4, 1'b1, 4'h4, 8'h5A, 2'd2, 1'b1};
      tbl[18] = '{1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b1, 4'h0, 8'h5A, 2'd2, 1'b0};

      // reset state
      drive(1'b1, 8'h11, 2'd0, 1'b0, 4'hF);
      chk("rst_in_ready", 32'(in_ready), 0);
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_in_ready_idle", 32'(in_ready), 1);
      chk("rst_drop_pulse", 32'(drop_pulse), 0);
      chk("rst_drop_cnt", 32'(drop_cnt), 0);

      // asynchronous reset mid-SEND after rr_ptr has moved to 1
      drive(1'b1, 8'hD0, 2'd2, 1'b1, 4'hF);
      cyc();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
      chk("t5_first_sel", 32'(sel), 0);
      cyc();
      drive(1'b1, 8'hD1, 2'd0, 1'b1, 4'h0);
      cyc();
      drive(1'b0, 8'h00, 2'd0, 1'b1, 4'h0);
      chk("t5_second_sel", 32'(sel), 1);
      chk("t5_second_ov", 32'(out_valid), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_ov", 32'(out_valid), 0);
      chk("t5_async_ir", 32'(in_ready), 0);
      chk("t5_async_busy", 32'(busy), 0);
      chk("t5_async_drop_cnt", 32'(drop_cnt), 0);
      drive(1'b1, 8'hE0, 2'd1, 1'b0, 4'hF);
      cyc();
      chk("t5_hold_ov", 32'(out_valid), 0);
      chk("t5_hold_ir", 32'(in_ready), 0);
      rst_n = 1'b1;
      drive(1'b1, 8'hE1, 2'd3, 1'b1, 4'hF);
      cyc();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
      chk("t5_rr_restart_sel", 32'(sel), 0);
      chk("t5_rr_restart_ov", 32'(out_valid), 1);
      chk("t5_rr_restart_data", 32'(out_data), 32'hE1);
      cyc();
      chk("t5_no_drop_pulse", 32'(drop_pulse), 0);
      chk("t5_no_drop_cnt", 32'(drop_cnt), 0);
      do_reset();

      // back-to-back addressed, round-robin wrap, and single-channel stall
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].dst, tbl[i].m, tbl[i].rdy);
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_d));
         chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].e_sel));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         cyc();
      end

      // timeout drops on a stalled channel, drop_cnt saturation
      for (int k = 1; k <= 256; k++) begin
         drive(1'b1, 8'(k), 2'd1, 1'b0, 4'h0);
         cyc();
         drive(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
         for (int j = 0; j < 4; j++) begin
            if (k == 1) begin
               chk($sformatf("t4_send%0d_ov", j), 32'(out_valid), 2);
               chk($sformatf("t4_send%0d_busy", j), 32'(busy), 1);
               chk($sformatf("t4_send%0d_ir", j), 32'(in_ready), 0);
               chk($sformatf("t4_send%0d_pulse", j), 32'(drop_pulse), 0);
            end
            cyc();
         end
         if (k == 1) begin
            chk("t4_drop_busy", 32'(busy), 0);
            chk("t4_drop_ov", 32'(out_valid), 0);
            chk("t4_drop_pulse", 32'(drop_pulse), 1);
            chk("t4_drop_ir", 32'(in_ready), 1);
         end
         if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256)
            chk($sformatf("t4_drop_cnt_%0d", k), 32'(drop_cnt), (k > 255) ? 255 : k);
         cyc();
         if (k == 1) begin
            chk("t4_pulse_clear", 32'(drop_pulse), 0);
            chk("t4_cnt_hold", 32'(drop_cnt), 1);
         end
      end

      // mode toggled while a round-robin word stalls; rr_ptr is 1 here
      drive(1'b1, 8'hC6, 2'd3, 1'b1, 4'h0);
      cyc();
      drive(1'b0, 8'h00, 2'd3, 1'b0, 4'h0);
      chk("t6_sel", 32'(sel), 1);
      chk("t6_ov", 32'(out_valid), 2);
      cyc();
      drive(1'b0, 8'h00, 2'd3, 1'b0, 4'hD);
      chk("t6_sel_after_toggle", 32'(sel), 1);
      chk("t6_data", 32'(out_data), 32'hC6);
      chk("t6_other_ready_ignored", 32'(in_ready), 0);
      cyc();
      drive(1'b0, 8'h00, 2'd3, 1'b0, 4'h2);
      chk("t6_xfer_ir", 32'(in_ready), 1);
      cyc();
      drive(1'b1, 8'hC7, 2'd0, 1'b1, 4'hF);
      cyc();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
      chk("t6_rr_advanced_once", 32'(sel), 2);
      cyc();
      // a dropped round-robin word also advances the pointer (3 -> 0)
      drive(1'b1, 8'hC8, 2'd0, 1'b1, 4'h0);
      cyc();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
      chk("t6_rr_sel3", 32'(sel), 3);
      repeat (4) cyc();
      chk("t6_rr_drop_pulse", 32'(drop_pulse), 1);
      chk("t6_rr_drop_cnt_sat", 32'(drop_cnt), 255);
      drive(1'b1, 8'hC9, 2'd3, 1'b1, 4'hF);
      cyc();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
      chk("t6_rr_wrap_after_drop", 32'(sel), 0);
      chk("t6_rr_wrap_data", 32'(out_data), 32'hC9);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
